piezo_sched: RTL and testbench

PIEZO_SCHED -- requirements
Module: piezo_sched

---
 rtl/piezo_sched.sv | 192 +++++++++++++++++++
 tb/tb_piezo_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/piezo_sched.sv
// Piezo alert scheduler: arbitrates three alert requests and sequences note/gap
// timing for an external tone generator. All outputs are registered.
module piezo_sched #(
  parameter bit          fast_sim   = 1'b0,
  parameter int unsigned fast_shift = 6   // duration divisor exponent applied when fast_sim=1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        en_steer,
  output logic        tone_en,
  output logic [14:0] half_per,
  output logic        note_start,
  output logic [1:0]  active_src
);

  localparam int unsigned SH = fast_sim ? fast_shift : 0;

  localparam logic [27:0] ND_LAST = 28'((32'd1 << (23 - SH)) - 32'd1);
  localparam logic [27:0] GB_LAST = 28'((32'd1 << (25 - SH)) - 32'd1);
  localparam logic [27:0] GS_LAST = 28'((32'd1 << (27 - SH)) - 32'd1);

  localparam logic [14:0] G6 = 15'd15944;
  localparam logic [14:0] C7 = 15'd11945;
  localparam logic [14:0] E7 = 15'd9480;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_STEER = 2'b01;
  localparam logic [1:0] SRC_BATT  = 2'b10;
  localparam logic [1:0] SRC_FAST  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic [1:0]  idx_q, idx_d;
  logic [27:0] cnt_q, cnt_d;
  logic        tone_en_q, tone_en_d;
  logic [14:0] half_per_q, half_per_d;
  logic        note_start_q, note_start_d;
  logic [1:0]  active_src_q, active_src_d;

  logic [2:0]  req;
  logic [1:0]  hi, pend, launch_src;
  logic        held, launch;
  logic [27:0] gap_last;

  // req bit order: [2]=too_fast, [1]=batt_low, [0]=en_steer
  function automatic logic [1:0] top_src(input logic [2:0] r);
    if (r[2])      return SRC_FAST;
    else if (r[1]) return SRC_BATT;
    else if (r[0]) return SRC_STEER;
    else           return SRC_NONE;
  endfunction

  function automatic logic [2:0] src_bit(input logic [1:0] s);
    case (s)
      SRC_STEER: return 3'b001;
      SRC_BATT:  return 3'b010;
      SRC_FAST:  return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [14:0] note_hp(input logic [1:0] s, input logic [1:0] i);
    case ({s, i})
      {SRC_FAST,  2'd0}: return G6;
      {SRC_FAST,  2'd1}: return C7;
      {SRC_FAST,  2'd2}: return E7;
      {SRC_BATT,  2'd0}: return E7;
      {SRC_BATT,  2'd1}: return C7;
      {SRC_BATT,  2'd2}: return G6;
      {SRC_STEER, 2'd0}: return G6;
      default:           return 15'd0;
    endcase
  endfunction

  always_comb begin
    req        = {too_fast, batt_low, en_steer};
    hi         = top_src(req);
    held       = |(req & src_bit(src_q));
    pend       = top_src(req & ~src_bit(src_q));
    gap_last   = (src_q == SRC_BATT) ? GB_LAST : GS_LAST;
    state_d    = state_q;
    src_d      = src_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + 28'd1;
    note_start_d = 1'b0;
    launch     = 1'b0;
    launch_src = SRC_NONE;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hi != SRC_NONE) begin
          launch     = 1'b1;
          launch_src = hi;
        end
      end
      S_NOTE: begin
        if (hi > src_q) begin
          launch     = 1'b1;
          launch_src = hi;
        end else if (cnt_q == ND_LAST) begin
          cnt_d = '0;
          if (held && src_q == SRC_FAST) begin
            idx_d        = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            note_start_d = 1'b1;
          end else if (held && src_q == SRC_BATT && idx_q != 2'd2) begin
            idx_d        = idx_q + 2'd1;
            note_start_d = 1'b1;
          end else if (held) begin
            state_d = S_GAP;
            idx_d   = '0;
          end else if (hi != SRC_NONE) begin
            // active request gone: skip the gap and hand over directly
            launch     = 1'b1;
            launch_src = hi;
          end else begin
            state_d = S_IDLE;
            src_d   = SRC_NONE;
            idx_d   = '0;
          end
        end
      end
      S_GAP: begin
        // the gap counts as sequence end, so any other request wins here
        if (pend != SRC_NONE) begin
          launch     = 1'b1;
          launch_src = pend;
        end else if (!held) begin
          state_d = S_IDLE;
          src_d   = SRC_NONE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == gap_last) begin
          state_d      = S_NOTE;
          idx_d        = '0;
          cnt_d        = '0;
          note_start_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        src_d   = SRC_NONE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (launch) begin
      state_d      = S_NOTE;
      src_d        = launch_src;
      idx_d        = '0;
      cnt_d        = '0;
      note_start_d = 1'b1;
    end

    tone_en_d    = (state_d == S_NOTE);
    half_per_d   = tone_en_d ? note_hp(src_d, idx_d) : '0;
    active_src_d = src_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= SRC_NONE;
      idx_q        <= '0;
      cnt_q        <= '0;
      tone_en_q    <= 1'b0;
      half_per_q   <= '0;
      note_start_q <= 1'b0;
      active_src_q <= SRC_NONE;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tone_en_q    <= tone_en_d;
      half_per_q   <= half_per_d;
      note_start_q <= note_start_d;
      active_src_q <= active_src_d;
    end
  end

  assign tone_en    = tone_en_q;
  assign half_per   = half_per_q;
  assign note_start = note_start_q;
  assign active_src = active_src_q;

endmodule

// File: tb/tb_piezo_sched.sv
// Bench for piezo_sched: randomized request timing checked against a timeline
// model of the alert sequences (durations shortened via fast_shift).
module tb_piezo_sched;

  localparam int unsigned SHIFT = 14;
  localparam int ND = 1 << (23 - SHIFT);
  localparam int GB = 1 << (25 - SHIFT);
  localparam int GS = 1 << (27 - SHIFT);

  logic        clk = 1'b0;
  logic        rst_n, too_fast, batt_low, en_steer;
  logic        tone_en, note_start;
  logic [14:0] half_per;
  logic [1:0]  active_src;
  logic [18:0] obs;
  logic [18:0] exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  piezo_sched #(.fast_sim(1'b1), .fast_shift(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .too_fast(too_fast), .batt_low(batt_low),
    .en_steer(en_steer), .tone_en(tone_en), .half_per(half_per),
    .note_start(note_start), .active_src(active_src)
  );

  always #10 clk = ~clk;
  assign obs = {tone_en, half_per, note_start, active_src};

  // i-th note of a sequence: too_fast G6,C7,E7; batt_low E7,C7,G6; en_steer G6
  function automatic int note_of(int src, int i);
    if (src == 3) return (i == 0) ? 15944 : (i == 1) ? 11945 : 9480;
    if (src == 2) return (i == 0) ? 9480  : (i == 1) ? 11945 : 15944;
    return 15944;
  endfunction

  // expected {tone_en, half_per, note_start, active_src} t edges after a
  // sequence started and with its request held continuously
  function automatic logic [18:0] exp_vec(int src, int t);
    int hp, p, n_notes, period;
    logic ns;
    hp = 0; ns = 1'b0;
    n_notes = (src == 1) ? 1 : 3;
    period  = (src == 3) ? 3*ND : (src == 2) ? 3*ND + GB : ND + GS;
    if (src != 0) begin
      p = t % period;
      if (p < n_notes*ND) begin
        hp = note_of(src, p / ND);
        ns = ((p % ND) == 0);
      end
    end
    return {hp != 0, hp[14:0], ns, src[1:0]};
  endfunction

  function automatic int best(logic [2:0] r);
    return r[2] ? 3 : r[1] ? 2 : r[0] ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 19'd0) begin n_fail++; $display("FAIL reset_state got %h want 0", obs); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (obs !== 19'd0) begin n_fail++; $display("FAIL idle_quiet cyc=%0d got %h want 0", i, obs); end
      tick();
    end
  endtask

  // en_steer alone through two periods, too_fast raised during the second gap
  task automatic test_steer();
    int tr;
    tr = 2*ND + GS + 12 + int'($urandom_range(0, GS - ND - 40));
    en_steer = 1'b1;
    tick();
    for (int t = 0; t <= tr; t++) begin
      exp_v = exp_vec(1, t);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL steer t=%0d got %h want %h", t, obs, exp_v); end
      if (t == tr) too_fast = 1'b1;
      tick();
    end
  endtask

  // too_fast preempted the gap; loops with no gap, then drops mid-note
  task automatic test_fast_from_gap();
    int d, e;
    d = 4*ND + int'($urandom_range(0, ND - 1));
    e = ((d + ND) / ND) * ND;
    for (int t = 0; t <= e + 20; t++) begin
      exp_v = (t < e) ? exp_vec(3, t) : 19'd0;
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL fast_gap t=%0d got %h want %h", t, obs, exp_v); end
      if (t == d) begin too_fast = 1'b0; en_steer = 1'b0; end
      tick();
    end
  endtask

  // simultaneous too_fast+batt_low; too_fast dropped mid-C7; batt_low dropped in gap
  task automatic test_simultaneous();
    int d, e, g;
    d = ND + int'($urandom_range(0, ND - 2));
    e = 2*ND;
    g = 3*ND + int'($urandom_range(0, GB - 2));
    too_fast = 1'b1;
    batt_low = 1'b1;
    tick();
    for (int t = 0; t <= e + g + 10; t++) begin
      if (t < e)           exp_v = exp_vec(3, t);
      else if (t - e <= g) exp_v = exp_vec(2, t - e);
      else                 exp_v = 19'd0;
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL simul t=%0d got %h want %h", t, obs, exp_v); end
      if (t == d)     too_fast = 1'b0;
      if (t == e + g) batt_low = 1'b0;
      tick();
    end
  endtask

  // en_steer raised while batt_low plays waits for batt_low's gap
  task automatic test_pending();
    int q, td;
    q  = int'($urandom_range(1, 3*ND - 2));
    td = 3*ND + 1 + ND + int'($urandom_range(5, 200));
    batt_low = 1'b1;
    tick();
    for (int t = 0; t <= td + 5; t++) begin
      if (t <= 3*ND)   exp_v = exp_vec(2, t);
      else if (t <= td) exp_v = exp_vec(1, t - 3*ND - 1);
      else              exp_v = 19'd0;
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pending t=%0d got %h want %h", t, obs, exp_v); end
      if (t == q)    en_steer = 1'b1;
      if (t == 3*ND) batt_low = 1'b0;
      if (t == td)   en_steer = 1'b0;
      tick();
    end
  endtask

  task automatic test_random_priority();
    logic [2:0] r;
    int h, k, w;
    for (int it = 0; it < 8; it++) begin
      r = 3'($urandom_range(1, 7));
      h = best(r);
      k = int'($urandom_range(0, 2*ND));
      {too_fast, batt_low, en_steer} = r;
      tick();
      for (int t = 0; t <= k; t++) begin
        exp_v = exp_vec(h, t);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL prio it=%0d req=%b t=%0d got %h want %h", it, r, t, obs, exp_v); end
        if (t == k) {too_fast, batt_low, en_steer} = 3'b000;
        tick();
      end
      w = 0;
      while (w < 2*ND + 4 && obs !== 19'd0) begin
        tick();
        w++;
      end
      n_checks++;
      if (obs !== 19'd0) begin n_fail++; $display("FAIL prio_release it=%0d got %h want 0", it, obs); end
    end
  endtask

  task automatic test_reset_mid();
    too_fast = 1'b1;
    tick();
    repeat ($urandom_range(5, 2*ND)) tick();
    n_checks++;
    if (tone_en !== 1'b1) begin n_fail++; $display("FAIL pre_reset_tone got %b want 1", tone_en); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 19'd0) begin n_fail++; $display("FAIL async_reset got %h want 0", obs); end
    too_fast = 1'b0;
    #5 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs !== 19'd0) begin n_fail++; $display("FAIL post_reset_idle cyc=%0d got %h want 0", i, obs); end
    end
    en_steer = 1'b1;
    tick();
    exp_v = exp_vec(1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset_start got %h want %h", obs, exp_v); end
    en_steer = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    too_fast = 1'b0;
    batt_low = 1'b0;
    en_steer = 1'b0;
    test_reset();
    test_steer();
    test_fast_from_gap();
    test_simultaneous();
    test_pending();
    test_random_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
